dht11_poll_sched: RTL and testbench
===================================

DHT11_POLL_SCHED -- requirements
Module: dht11_poll_sched

Interface
REQ-001 The block SHALL have parameter POLL_PERIOD, default 50_000_000, clock cycles between scheduled sensor reads.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 30_000_000, maximum cycles to wait for drv_done after drv_start.
REQ-003 The block SHALL have parameter HOLDOFF_CYCLES, default 2_000_000, minimum idle gap after any transaction ends.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, failed attempts allowed per scheduled read.
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  periodic polling allowed.
- trigger  in  1  one-cycle manual read request.
- drv_start  out  1  one-cycle start pulse to the DHT11 driver.
- drv_done  in  1  one-cycle driver frame-complete pulse.
- drv_data  in  40  driver frame: [39:32] RH int, [31:24] RH dec, [23:16] T int, [15:8] T dec, [7:0] checksum.
- humidity  out  8  last valid RH integer.
- temperature  out  8  last valid T integer.
- valid  out  1  at least one good frame captured.
- sample_stb  out  1  one-cycle pulse on each humidity/temperature update.
- err_stb  out  1  one-cycle pulse when retries are exhausted.
- busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-006 The FSM SHALL have the states IDLE, START, WAIT, CHECK and HOLDOFF.
REQ-007 The period counter SHALL count only while enable=1; it SHALL be held at 0 while enable=0; on reaching POLL_PERIOD-1 it SHALL raise a request and wrap to 0.
REQ-008 In IDLE, a period request or trigger SHALL move the FSM to START and clear retry_cnt; simultaneous request and trigger SHALL produce one transaction; a trigger outside IDLE SHALL be ignored.
REQ-009 START SHALL last exactly one cycle with drv_start=1, then go to WAIT with the timeout counter cleared.
REQ-010 In WAIT, drv_done=1 SHALL register drv_data and go to CHECK; if the timeout counter reaches TIMEOUT_CYCLES-1 first, the attempt SHALL be marked failed.
REQ-011 CHECK SHALL pass when (sum of drv_data bytes [39:32],[31:24],[23:16],[15:8]) mod 256 == drv_data[7:0], using an 8-bit wrap-around sum.
REQ-012 On pass, the block SHALL load humidity and temperature, set valid=1 and pulse sample_stb, all visible on the cycle after CHECK, then go to HOLDOFF with no retry pending.
REQ-013 On fail (checksum or timeout), the block SHALL increment retry_cnt; if retry_cnt < MAX_RETRY the block SHALL go to HOLDOFF with a retry pending, otherwise it SHALL pulse err_stb, go to HOLDOFF with no retry pending, and leave humidity, temperature and valid unchanged.
REQ-014 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles, then go to START if a retry is pending, else to IDLE.
REQ-015 A retry SHALL NOT require enable=1.
REQ-016 Period requests occurring outside IDLE SHALL be dropped, not queued.
REQ-017 drv_done outside WAIT SHALL be ignored.
REQ-018 Deasserting enable mid-transaction SHALL let the transaction and its retries complete.

Reset
REQ-019 While rst=1 at a clk edge, the FSM SHALL go to IDLE, and all counters and retry_cnt SHALL clear.
REQ-020 While rst=1, humidity, temperature, valid, sample_stb, err_stb, drv_start and busy SHALL all be 0.
REQ-021 A reset applied mid-WAIT SHALL abandon the transaction and the following START SHALL come only from a new request.

Configuration
REQ-022 With DHT11_SCHED_STATS_EN defined, the block SHALL add outputs crc_err_cnt[15:0] and timeout_cnt[15:0], which count failed attempts by cause, saturate at 16'hFFFF and clear on reset.
REQ-023 Without DHT11_SCHED_STATS_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-024 Package dht11_pkg SHALL hold the FSM state enum, the frame byte-offset constants and the checksum function.
REQ-025 The checksum comparison SHALL be a sub-module named dht11_frame_check (40-bit in, pass out, combinational) instantiated once; the FSM and counters SHALL stay in the top level.

Verification
Bench parameters: POLL_PERIOD=100, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=10, MAX_RETRY=2.
REQ-026 Good frame: enable=1, driver returns 40'h3700_1A00_51 -> sample_stb fires once, humidity=8'h37, temperature=8'h1A, valid=1, no err_stb.
REQ-027 Bad checksum: driver returns 40'h3700_1A00_50 twice -> two drv_start pulses 10+ cycles apart, one err_stb, valid stays 0.
REQ-028 Timeout then good frame: first drv_done is withheld -> second drv_start follows 50+10 cycles after the first, then the good frame updates the outputs.
REQ-029 Trigger while enable=0 -> one transaction runs; trigger asserted during WAIT -> no extra drv_start.
REQ-030 Reset mid-WAIT, then drv_done -> drv_done is ignored, all outputs are 0 and no drv_start appears until the next request.
REQ-031 With DHT11_SCHED_STATS_EN defined: one checksum failure and one timeout -> crc_err_cnt=1 and timeout_cnt=1.

Source files
------------

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared FSM states, frame byte offsets and checksum for the DHT11 poll scheduler
package dht11_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, HOLDOFF} state_t;
  localparam int RH_INT_LSB = 32;
  localparam int RH_DEC_LSB = 24;
  localparam int T_INT_LSB = 16;
  localparam int T_DEC_LSB = 8;
  localparam int CSUM_LSB = 0;
  function automatic logic [7:0] frame_sum(input logic [39:0] f);
    return f[RH_INT_LSB +: 8] + f[RH_DEC_LSB +: 8] + f[T_INT_LSB +: 8] + f[T_DEC_LSB +: 8];
  endfunction
endpackage

// File: rtl/dht11_frame_check.sv
// dht11_frame_check: combinational DHT11 frame checksum comparison
module dht11_frame_check
  import dht11_pkg::*;
(
  input  logic [39:0] frame,
  output logic        pass
);
  assign pass = frame_sum(frame) == frame[CSUM_LSB +: 8];
endmodule

// File: rtl/dht11_poll_sched.sv
// dht11_poll_sched: periodic/manual DHT11 read scheduler with timeout, retry and holdoff
// Optional DHT11_SCHED_STATS_EN adds crc_err_cnt/timeout_cnt failure counters.
module dht11_poll_sched
  import dht11_pkg::*;
#(
  parameter int POLL_PERIOD    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 30_000_000,
  parameter int HOLDOFF_CYCLES = 2_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trigger,
  output logic        drv_start,
  input  logic        drv_done,
  input  logic [39:0] drv_data,
  output logic [7:0]  humidity,
  output logic [7:0]  temperature,
  output logic        valid,
  output logic        sample_stb,
  output logic        err_stb,
  output logic        busy
`ifdef DHT11_SCHED_STATS_EN
  ,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] timeout_cnt
`endif
);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] retry_cnt;
  logic retry_pend;
  logic [39:0] frame;
  logic pass, per_req, tmo_hit, crc_bad, fail, last_try, hold_done;
  dht11_frame_check u_check (.frame(frame), .pass(pass));
  assign per_req   = enable && per_cnt == PW'(POLL_PERIOD - 1);
  assign tmo_hit   = state == WAIT && !drv_done && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign crc_bad   = state == CHECK && !pass;
  assign fail      = tmo_hit || crc_bad;
  assign last_try  = 32'(retry_cnt) + 1 >= MAX_RETRY;
  assign hold_done = hold_cnt == HW'(HOLDOFF_CYCLES - 1);
  assign drv_start = state == START;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst || !enable || per_req) per_cnt <= '0;
    else per_cnt <= per_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      retry_cnt   <= '0;
      retry_pend  <= 1'b0;
      frame       <= '0;
      humidity    <= '0;
      temperature <= '0;
      valid       <= 1'b0;
      sample_stb  <= 1'b0;
      err_stb     <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      err_stb    <= 1'b0;
      case (state)
        IDLE: if (per_req || trigger) begin
          state     <= START;
          retry_cnt <= '0;
        end
        START: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: if (drv_done) begin
          frame <= drv_data;
          state <= CHECK;
        end else tmo_cnt <= tmo_cnt + 1'b1;
        CHECK: if (pass) begin
          humidity    <= frame[RH_INT_LSB +: 8];
          temperature <= frame[T_INT_LSB +: 8];
          valid       <= 1'b1;
          sample_stb  <= 1'b1;
          retry_pend  <= 1'b0;
          state       <= HOLDOFF;
        end
        HOLDOFF: begin
          hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
          if (hold_done) state <= retry_pend ? START : IDLE;
        end
        default: state <= IDLE;
      endcase
      // timeout and checksum failures share the retry/give-up decision
      if (fail) begin
        retry_cnt  <= retry_cnt + 1'b1;
        retry_pend <= !last_try;
        err_stb    <= last_try;
        state      <= HOLDOFF;
      end
    end
  end
`ifdef DHT11_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (crc_bad && ~&crc_err_cnt) crc_err_cnt <= crc_err_cnt + 1'b1;
      if (tmo_hit && ~&timeout_cnt) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dht11_poll_sched.sv
// tb_dht11_poll_sched: vector table, corner sequences and randomized reads against a frame-level model
module tb_dht11_poll_sched;
  localparam int PP = 100, TO = 50, HO = 10, MR = 2;
  logic clk = 0, rst = 1, enable = 0, trigger = 0, drv_done = 0;
  logic [39:0] drv_data = '0;
  logic drv_start, valid, sample_stb, err_stb, busy;
  logic [7:0] humidity, temperature;
`ifdef DHT11_SCHED_STATS_EN
  logic [15:0] crc_err_cnt, timeout_cnt;
`endif
  dht11_poll_sched #(.POLL_PERIOD(PP), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .drv_start(drv_start),
    .drv_done(drv_done), .drv_data(drv_data), .humidity(humidity), .temperature(temperature),
    .valid(valid), .sample_stb(sample_stb), .err_stb(err_stb), .busy(busy)
`ifdef DHT11_SCHED_STATS_EN
    , .crc_err_cnt(crc_err_cnt), .timeout_cnt(timeout_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int delay; bit withhold; logic [39:0] data;} resp_t;
  typedef struct {resp_t a; resp_t b; int starts; bit err; logic [7:0] h; logic [7:0] t;} vec_t;
  resp_t plan[$];
  int st_times[$];
  int checks = 0, errors = 0, cyc = 0, n_start = 0, n_sample = 0, n_err = 0;
  bit pend = 0;
  int cd = 0;
  logic [39:0] pd = '0;
  logic [7:0] m_h = 0, m_t = 0;
  bit m_valid = 0;
  always @(negedge clk) begin
    cyc++;
    if (drv_start) begin n_start++; st_times.push_back(cyc); end
    if (sample_stb) n_sample++;
    if (err_stb) n_err++;
  end
  // driver stand-in: answers each drv_start from the plan queue after its delay
  always @(negedge clk) begin
    resp_t p;
    drv_done = 0;
    if (pend) begin
      cd--;
      if (cd == 0) begin drv_done = 1; drv_data = pd; pend = 0; end
    end
    if (drv_start && plan.size() > 0) begin
      p = plan.pop_front();
      pend = !p.withhold; cd = p.delay; pd = p.data;
    end
  end
  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic clear_mon();
    n_start = 0; n_sample = 0; n_err = 0; st_times.delete();
  endtask
  task automatic wait_idle(string nm);
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
  endtask
  task automatic run_txn(string nm, resp_t a, resp_t b);
    plan.delete(); plan.push_back(a); plan.push_back(b);
    clear_mon();
    trigger = 1; @(negedge clk); trigger = 0;
    wait_idle(nm);
  endtask
  function automatic int gap();
    return st_times.size() >= 2 ? st_times[1] - st_times[0] : 0;
  endfunction
  function automatic resp_t mk(int kind, int delay, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    int s;
    resp_t r;
    s = (int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256;
    if (kind == 1) s = (s + int'($urandom_range(1, 255))) % 256;
    r.delay = delay; r.withhold = kind == 2; r.data = {b0, b1, b2, b3, 8'(s)};
    return r;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[6];
    resp_t r[MR];
    int n, exp_starts;
    bit exp_err;
    tbl[0] = '{'{5, 0, 40'h3700_1A00_51}, '{5, 0, 40'h0}, 1, 0, 8'h37, 8'h1A};
    tbl[1] = '{'{5, 0, 40'h3700_1A00_50}, '{7, 0, 40'h3700_1A00_50}, 2, 1, 8'h37, 8'h1A};
    tbl[2] = '{'{5, 1, 40'h0}, '{9, 0, 40'h2A05_1903_4B}, 2, 0, 8'h2A, 8'h19};
    tbl[3] = '{'{40, 0, 40'hFFFF_FFFF_FC}, '{5, 0, 40'h0}, 1, 0, 8'hFF, 8'hFF};
    tbl[4] = '{'{1, 0, 40'h1000_2000_31}, '{3, 0, 40'h1000_2000_30}, 2, 0, 8'h10, 8'h20};
    tbl[5] = '{'{5, 1, 40'h0}, '{5, 1, 40'h0}, 2, 1, 8'h10, 8'h20};
    repeat (3) @(negedge clk);
    chk("rst_outs", {humidity, temperature, valid, sample_stb, err_stb, drv_start, busy}, 0);
    rst = 0;
    @(negedge clk);
    run_txn("bad2", '{5, 0, 40'h3700_1A00_50}, '{5, 0, 40'h3700_1A00_50});
    chk("bad2_starts", n_start, 2);
    chk("bad2_err", n_err, 1);
    chk("bad2_sample", n_sample, 0);
    chk("bad2_valid", valid, 0);
    chk("bad2_gap", gap() >= HO + 1, 1);
    plan.delete(); plan.push_back('{5, 0, 40'h3700_1A00_51});
    clear_mon();
    enable = 1;
    n = 0;
    for (int i = 0; i < 300 && !busy; i++) begin @(negedge clk); n = i + 1; end
    chk("period_len", n, PP);
    wait_idle("period");
    enable = 0;
    chk("good_starts", n_start, 1);
    chk("good_sample", n_sample, 1);
    chk("good_err", n_err, 0);
    chk("good_h", humidity, 8'h37);
    chk("good_t", temperature, 8'h1A);
    chk("good_valid", valid, 1);
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_starts", i), n_start, tbl[i].starts);
      chk($sformatf("vec%0d_err", i), n_err, tbl[i].err);
      chk($sformatf("vec%0d_sample", i), n_sample, !tbl[i].err);
      chk($sformatf("vec%0d_h", i), humidity, tbl[i].h);
      chk($sformatf("vec%0d_t", i), temperature, tbl[i].t);
      chk($sformatf("vec%0d_valid", i), valid, 1);
      if (tbl[i].starts == 2) chk($sformatf("vec%0d_gap", i), gap() >= (tbl[i].a.withhold ? TO + HO : HO + 1), 1);
    end
    plan.delete(); plan.push_back('{30, 0, 40'h2211_3344_AA});
    clear_mon();
    trigger = 1; @(negedge clk); trigger = 0;
    repeat (5) @(negedge clk);
    trigger = 1; @(negedge clk); trigger = 0;
    wait_idle("trig_wait");
    chk("trig_wait_starts", n_start, 1);
    chk("trig_wait_h", humidity, 8'h22);
    chk("trig_wait_t", temperature, 8'h33);
    plan.delete(); plan.push_back('{30, 0, 40'h0102_0304_0A});
    clear_mon();
    trigger = 1; @(negedge clk); trigger = 0;
    repeat (10) @(negedge clk);
    chk("midwait_busy", busy, 1);
    rst = 1; @(negedge clk);
    chk("midwait_rst_outs", {humidity, temperature, valid, sample_stb, err_stb, drv_start, busy}, 0);
    @(negedge clk); rst = 0;
    repeat (60) @(negedge clk);
    chk("midwait_starts", n_start, 1);
    chk("midwait_sample", n_sample, 0);
    chk("midwait_outs", {humidity, temperature, valid, busy}, 0);
    m_h = 0; m_t = 0; m_valid = 0;
    run_txn("stats", '{4, 0, 40'h0102_0304_0B}, '{4, 1, 40'h0});
    chk("stats_err", n_err, 1);
`ifdef DHT11_SCHED_STATS_EN
    chk("stats_crc", crc_err_cnt, 1);
    chk("stats_tmo", timeout_cnt, 1);
`endif
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < MR; k++)
        r[k] = mk($urandom_range(0, 2), $urandom_range(1, 40), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      exp_starts = MR; exp_err = 1;
      for (int k = 0; k < MR; k++)
        if (exp_err && !r[k].withhold && (r[k].data[39:32] + r[k].data[31:24] + r[k].data[23:16] + r[k].data[15:8]) % 256 == 32'(r[k].data[7:0])) begin
          exp_starts = k + 1; exp_err = 0;
          m_h = r[k].data[39:32]; m_t = r[k].data[23:16]; m_valid = 1;
        end
      run_txn($sformatf("rnd%0d", it), r[0], r[1]);
      chk($sformatf("rnd%0d_starts", it), n_start, exp_starts);
      chk($sformatf("rnd%0d_err", it), n_err, exp_err);
      chk($sformatf("rnd%0d_sample", it), n_sample, !exp_err);
      chk($sformatf("rnd%0d_h", it), humidity, m_h);
      chk($sformatf("rnd%0d_t", it), temperature, m_t);
      chk($sformatf("rnd%0d_valid", it), valid, m_valid);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
